fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage plus IF/ID pipeline register feeding the decode stage.
//   Owns the PC and drives a ready-handshaked instruction memory.
//   Consumes the hazard unit's stall (freeze) and the EXE stage's branch redirect.
//   One instruction per cycle when memory is zero-wait and no freeze is present.
// PARAMETERS
//   ADDR_W    32  PC / memory address width; PC advances by 4.
//   INSTR_W   32  instruction width.
//   RESET_PC  0   PC value loaded at reset.
//   CNT_W     16  width of the stall-cycle counter.
// PORTS
//   clk          in   1        clock; all state updates on the rising edge.
//   rst          in   1        asynchronous, active-low reset.
//   freeze       in   1        hazard-unit stall: hold PC and IF/ID.
//   branch_taken in   1        redirect from EXE; flushes IF/ID.
//   branch_addr  in   ADDR_W   redirect target.
//   imem_req     out  1        fetch request, combinational from state.
//   imem_addr    out  ADDR_W   fetch address (= pc); held stable while request pending.
//   imem_ready   in   1        memory returns imem_rdata this cycle.
//   imem_rdata   in   INSTR_W  fetched instruction.
//   ifid_valid   out  1        IF/ID holds a real instruction.
//   ifid_pc      out  ADDR_W   fetched address + 4.
//   ifid_instr   out  INSTR_W  fetched instruction.
//   stall_cnt    out  CNT_W    cycles with freeze=1, saturating.
// BEHAVIOUR
//   Reset (rst=0, asynchronous):
//     pc = RESET_PC; state = FETCH; ifid_valid/ifid_pc/ifid_instr = 0;
//     stall_cnt = 0; hold_buf and redir_pc = 0.
//   States: FETCH, HOLD, DISCARD.
//     imem_req = 1 in FETCH and DISCARD, 0 in HOLD; imem_addr = pc always.
//   FETCH, priority branch > freeze > normal:
//     branch_taken & imem_ready   -> drop data; pc <= branch_addr; ifid_valid <= 0; stay FETCH.
//     branch_taken & !imem_ready  -> redir_pc <= branch_addr; ifid_valid <= 0; go DISCARD.
//                                    pc is unchanged, so the address stays stable.
//     freeze & imem_ready         -> hold_buf <= imem_rdata; IF/ID and pc hold; go HOLD.
//     freeze & !imem_ready        -> everything holds.
//     imem_ready                  -> ifid <= {valid=1, pc+4, imem_rdata}; pc <= pc+4.
//     !imem_ready                 -> IF/ID holds its contents; ifid_valid is not cleared.
//   HOLD:
//     branch_taken -> drop hold_buf; pc <= branch_addr; ifid_valid <= 0; go FETCH.
//     freeze       -> hold.
//     otherwise    -> ifid <= {1, pc+4, hold_buf}; pc <= pc+4; go FETCH.
//   DISCARD (waiting out the abandoned request):
//     branch_taken -> redir_pc <= branch_addr (newest target wins); ifid_valid <= 0.
//     imem_ready   -> drop data; pc <= the updated redir_pc; go FETCH.
//     freeze       -> ignored here.
//   Freeze and branch on the same cycle: branch wins and IF/ID is flushed.
//   Latency: a zero-wait fetch issued in cycle N is visible on ifid_* after edge N.
//   pc+4 wraps modulo 2^ADDR_W with no flag. branch_addr is taken verbatim; no alignment check.
//   stall_cnt increments on every edge with freeze=1 and saturates at 2^CNT_W-1.
//   Reset mid-operation aborts any pending fetch.
//     The memory must tolerate imem_req dropping while a request is pending.
// TESTING
//   1. Zero-wait memory, ready=1, no freeze, from reset:
//      ifid_pc = 4,8,12 with matching instructions on consecutive cycles.
//   2. freeze=1 for 3 cycles while ready=1:
//      pc and ifid hold, state goes HOLD, stall_cnt = 3.
//      Freeze release -> buffered instruction appears, ifid_pc = previous + 4.
//   3. branch_taken with branch_addr=0x40 while ready=1:
//      next cycle ifid_valid = 0, imem_addr = 0x40; following cycle ifid_pc = 0x44.
//   4. Memory with a 2-cycle wait, branch to 0x80 during the wait:
//      state DISCARD, imem_addr stays at the old pc until ready.
//      Then imem_addr = 0x80; the stale instruction never reaches IF/ID.
//   5. freeze and branch_taken together in HOLD: ifid_valid = 0, pc = branch_addr.
//      Separately, pc = 0xFFFFFFFC fetched -> ifid_pc = 0 (wrap).
//   6. rst asserted mid-wait: all outputs 0 and pc = RESET_PC immediately.
//      Separately, freeze held with CNT_W=4 -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory request/response bundle between the fetch stage and
//   the instruction memory.
//   Signals:
//     imem_req    fetch request (fetch stage -> memory)
//     imem_addr   fetch address, held stable while a request is pending
//     imem_ready  memory returns imem_rdata this cycle (memory -> fetch stage)
//     imem_rdata  fetched instruction
//   Modports:
//     master  fetch-stage side
//     slave   memory side
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register.
//   Owns the PC, drives a ready-handshaked instruction memory, honours the
//   hazard unit's freeze and the EXE stage's branch redirect.
//   Ports:
//     clk           clock, rising edge
//     rst           asynchronous active-low reset
//     freeze        hold PC and IF/ID
//     branch_taken  redirect request, flushes IF/ID
//     branch_addr   redirect target (taken verbatim)
//     imem          instruction-memory bundle (master side)
//     ifid_valid    IF/ID holds a real instruction
//     ifid_pc       fetched address + 4
//     ifid_instr    fetched instruction
//     stall_cnt     saturating count of cycles with freeze=1
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_addr,
    fetch_stage_if.master       imem,
    output logic                ifid_valid,
    output logic [ADDR_W-1:0]   ifid_pc,
    output logic [INSTR_W-1:0]  ifid_instr,
    output logic [CNT_W-1:0]    stall_cnt
);

    // FETCH   : request outstanding at pc
    // HOLD    : instruction returned under freeze, parked in hold_buf
    // DISCARD : waiting out a request abandoned by a redirect
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    state_t              state_q,      state_d;
    logic [ADDR_W-1:0]   pc_q,         pc_d;
    logic [INSTR_W-1:0]  hold_buf_q,   hold_buf_d;
    logic [ADDR_W-1:0]   redir_pc_q,   redir_pc_d;
    logic                ifid_valid_q, ifid_valid_d;
    logic [ADDR_W-1:0]   ifid_pc_q,    ifid_pc_d;
    logic [INSTR_W-1:0]  ifid_instr_q, ifid_instr_d;
    logic [CNT_W-1:0]    stall_cnt_q,  stall_cnt_d;

    logic [ADDR_W-1:0]   pc_inc;

    // pc + 4 wraps naturally at the address width
    assign pc_inc = pc_q + PC_STEP;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_buf_d   = hold_buf_q;
        redir_pc_d   = redir_pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;

        unique case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    ifid_valid_d = 1'b0;
                    if (imem.imem_ready) begin
                        pc_d = branch_addr;
                    end else begin
                        // Keep pc (and thus imem_addr) stable until the
                        // in-flight request completes; remember the target.
                        redir_pc_d = branch_addr;
                        state_d    = DISCARD;
                    end
                end else if (freeze) begin
                    if (imem.imem_ready) begin
                        hold_buf_d = imem.imem_rdata;
                        state_d    = HOLD;
                    end
                end else if (imem.imem_ready) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = pc_inc;
                    ifid_instr_d = imem.imem_rdata;
                    pc_d         = pc_inc;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    ifid_valid_d = 1'b0;
                    pc_d         = branch_addr;
                    state_d      = FETCH;
                end else if (!freeze) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = pc_inc;
                    ifid_instr_d = hold_buf_q;
                    pc_d         = pc_inc;
                    state_d      = FETCH;
                end
            end

            DISCARD: begin
                // A branch arriving on the same edge as ready still wins:
                // the newest target is used directly.
                if (branch_taken) begin
                    redir_pc_d   = branch_addr;
                    ifid_valid_d = 1'b0;
                end
                if (imem.imem_ready) begin
                    pc_d    = branch_taken ? branch_addr : redir_pc_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (freeze && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            hold_buf_q   <= '0;
            redir_pc_q   <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_buf_q   <= hold_buf_d;
            redir_pc_q   <= redir_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign imem.imem_req  = (state_q != HOLD);
    assign imem.imem_addr = pc_q;

    assign ifid_valid = ifid_valid_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;
    assign stall_cnt  = stall_cnt_q;

endmodule
